// File: rtl/mig_pkg.sv
// rtl/mig_pkg.sv - shared constants, operand/node types and FSM states for the MIG sweeper
package mig_pkg;

  localparam int MIG_SEL_W  = 5;
  localparam int SEL_CONST0 = 0;
  localparam int SEL_X0     = 1;
  localparam int SEL_NODE0  = 8;

  typedef struct packed {
    logic                 inv;
    logic [MIG_SEL_W-1:0] sel;
  } mig_operand_t;

  typedef struct packed {
    mig_operand_t a;
    mig_operand_t b;
    mig_operand_t c;
  } mig_node_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } mig_state_t;

endpackage

// File: rtl/maj3_unit.sv
// rtl/maj3_unit.sv - combinational three-input majority with per-input complement
module maj3_unit (
  input  logic a_val_i,
  input  logic a_inv_i,
  input  logic b_val_i,
  input  logic b_inv_i,
  input  logic c_val_i,
  input  logic c_inv_i,
  output logic y_o
);

  logic a, b, c;

  assign a   = a_val_i ^ a_inv_i;
  assign b   = b_val_i ^ b_inv_i;
  assign c   = c_val_i ^ c_inv_i;
  assign y_o = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/mig_tt_sweeper.sv
// rtl/mig_tt_sweeper.sv - sweeps all 128 patterns of x0..x6 through a loaded MIG netlist,
// one node per cycle on a shared MAJ3, and assembles the last node's truth table
module mig_tt_sweeper
  import mig_pkg::*;
#(
  parameter int MAX_GATES = 16,
  parameter int SEL_W     = MIG_SEL_W,
  parameter int CNT_W     = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [CNT_W-1:0]       cfg_addr,
  input  logic [3*(SEL_W+1)-1:0] cfg_node,
  input  logic [CNT_W-1:0]       cfg_num,
  input  logic                   cfg_out_inv,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [127:0]           tt
);

  localparam int NODE_W = 3 * (SEL_W + 1);

  mig_state_t             state_q, state_d;
  logic [NODE_W-1:0]      node_tab_q [MAX_GATES];
  logic [MAX_GATES-1:0]   node_val_q;
  logic [6:0]             p_q;
  logic [CNT_W-1:0]       g_q;
  logic [CNT_W-1:0]       num_q;
  logic                   inv_q;
  logic [127:0]           tt_q;

  logic                   num_ok;
  logic                   last_gate;
  logic                   cfg_wr;
  logic [NODE_W-1:0]      cur_desc;
  mig_node_t              cur_node;
  logic                   va, vb, vc;
  logic                   maj_res;

  // Unmapped select codes fall through to 0, which is also the const0 value.
  function automatic logic operand_val(input logic [MIG_SEL_W-1:0] sel,
                                       input logic [6:0]           x,
                                       input logic [MAX_GATES-1:0] nv);
    logic r;
    r = 1'b0;
    if (int'(sel) == SEL_CONST0) r = 1'b0;
    for (int i = 0; i < 7; i++)
      if (int'(sel) == SEL_X0 + i) r = x[i];
    for (int k = 0; k < MAX_GATES; k++)
      if (int'(sel) == SEL_NODE0 + k) r = nv[k];
    return r;
  endfunction

  assign num_ok    = (cfg_num != '0) && (cfg_num <= CNT_W'(MAX_GATES));
  assign last_gate = (g_q == num_q - CNT_W'(1));
  assign cfg_wr    = cfg_we && (state_q == IDLE);

  always_comb begin
    cur_desc = '0;
    cur_node = '0;
    for (int k = 0; k < MAX_GATES; k++)
      if (g_q == CNT_W'(k)) cur_desc = node_tab_q[k];
    cur_node.a.inv = cur_desc[SEL_W];
    cur_node.a.sel = MIG_SEL_W'(cur_desc[SEL_W-1:0]);
    cur_node.b.inv = cur_desc[2*SEL_W+1];
    cur_node.b.sel = MIG_SEL_W'(cur_desc[2*SEL_W:SEL_W+1]);
    cur_node.c.inv = cur_desc[3*SEL_W+2];
    cur_node.c.sel = MIG_SEL_W'(cur_desc[3*SEL_W+1:2*SEL_W+2]);
  end

  assign va = operand_val(cur_node.a.sel, p_q, node_val_q);
  assign vb = operand_val(cur_node.b.sel, p_q, node_val_q);
  assign vc = operand_val(cur_node.c.sel, p_q, node_val_q);

  maj3_unit u_maj3 (
    .a_val_i (va),
    .a_inv_i (cur_node.a.inv),
    .b_val_i (vb),
    .b_inv_i (cur_node.b.inv),
    .c_val_i (vc),
    .c_inv_i (cur_node.c.inv),
    .y_o     (maj_res)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = num_ok ? EVAL : DONE;
      EVAL: if (last_gate && (p_q == 7'd127)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      node_val_q <= '0;
      p_q        <= '0;
      g_q        <= '0;
      num_q      <= '0;
      inv_q      <= 1'b0;
      tt_q       <= '0;
      for (int k = 0; k < MAX_GATES; k++) node_tab_q[k] <= '0;
    end else begin
      state_q <= state_d;
      if (cfg_wr)
        for (int k = 0; k < MAX_GATES; k++)
          if (cfg_addr == CNT_W'(k)) node_tab_q[k] <= cfg_node;
      case (state_q)
        IDLE: begin
          if (start) begin
            tt_q       <= '0;
            p_q        <= '0;
            g_q        <= '0;
            node_val_q <= '0;
            num_q      <= cfg_num;
            inv_q      <= cfg_out_inv;
          end
        end
        EVAL: begin
          // Clearing node values per pattern is what makes forward references read 0.
          if (last_gate) begin
            tt_q[p_q]  <= maj_res ^ inv_q;
            node_val_q <= '0;
            g_q        <= '0;
            p_q        <= p_q + 7'd1;
          end else begin
            for (int k = 0; k < MAX_GATES; k++)
              if (g_q == CNT_W'(k)) node_val_q[k] <= maj_res;
            g_q <= g_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q == EVAL);
  assign done = (state_q == DONE);
  assign tt   = tt_q;

endmodule

// File: tb/tb_mig_tt_sweeper.sv
// tb/tb_mig_tt_sweeper.sv - directed scoreboard bench for mig_tt_sweeper
module tb_mig_tt_sweeper;

  localparam int MAX_GATES = 16;
  localparam int SEL_W     = 5;
  localparam int CNT_W     = 5;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   cfg_we;
  logic [CNT_W-1:0]       cfg_addr;
  logic [3*(SEL_W+1)-1:0] cfg_node;
  logic [CNT_W-1:0]       cfg_num;
  logic                   cfg_out_inv;
  logic                   start;
  logic                   busy;
  logic                   done;
  logic [127:0]           tt;

  int errors = 0;
  int checks = 0;
  logic [127:0] sb_q[$];

  int tb_sel [MAX_GATES][3];
  bit tb_inv [MAX_GATES][3];

  always #5 clk = ~clk;

  mig_tt_sweeper #(.MAX_GATES(MAX_GATES), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_node(cfg_node),
    .cfg_num(cfg_num), .cfg_out_inv(cfg_out_inv), .start(start),
    .busy(busy), .done(done), .tt(tt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] pack_node(input int sa, input bit ia, input int sb,
                                            input bit ib, input int sc, input bit ic);
    return {ic, 5'(sc), ib, 5'(sb), ia, 5'(sa)};
  endfunction

  task automatic set_node(input int idx, input int sa, input bit ia, input int sb,
                          input bit ib, input int sc, input bit ic);
    tb_sel[idx][0] = sa; tb_inv[idx][0] = ia;
    tb_sel[idx][1] = sb; tb_inv[idx][1] = ib;
    tb_sel[idx][2] = sc; tb_inv[idx][2] = ic;
    cfg_we   = 1'b1;
    cfg_addr = CNT_W'(idx);
    cfg_node = pack_node(sa, ia, sb, ib, sc, ic);
    tick();
    cfg_we = 1'b0;
  endtask

  function automatic bit opv(input int sel, input bit inv, input int p, input bit nv[MAX_GATES]);
    bit v;
    if (sel == 0) v = 1'b0;
    else if (sel <= 7) v = p[sel-1];
    else if (sel < 8 + MAX_GATES) v = nv[sel-8];
    else v = 1'b0;
    return v ^ inv;
  endfunction

  function automatic logic [127:0] model_tt(input int num, input bit oinv);
    logic [127:0] r;
    bit nv [MAX_GATES];
    bit a, b, c, m;
    r = '0;
    for (int p = 0; p < 128; p++) begin
      for (int k = 0; k < MAX_GATES; k++) nv[k] = 1'b0;
      m = 1'b0;
      for (int g = 0; g < num; g++) begin
        a = opv(tb_sel[g][0], tb_inv[g][0], p, nv);
        b = opv(tb_sel[g][1], tb_inv[g][1], p, nv);
        c = opv(tb_sel[g][2], tb_inv[g][2], p, nv);
        m = (a & b) | (a & c) | (b & c);
        nv[g] = m;
      end
      r[p] = m ^ oinv;
    end
    return r;
  endfunction

  // Drives start in cycle 0 and follows the sweep; optional disturbances at the given cycles.
  task automatic sweep(input string tag, input int num, input bit oinv, input logic [127:0] exp_tt,
                       input int exp_done, input int restart_at, input int we_at, input int rst_at);
    int cyc, busy_cnt, dones, first_done;
    logic [127:0] exp;
    sb_q.push_back(exp_tt);
    cfg_num     = CNT_W'(num);
    cfg_out_inv = oinv;
    start       = 1'b1;
    tick();
    start  = 1'b0;
    cfg_we = 1'b0;
    cyc = 1; busy_cnt = 0; dones = 0; first_done = -1;
    while (cyc <= exp_done + 20) begin
      if (busy) busy_cnt++;
      if (done) begin
        dones++;
        if (first_done < 0) first_done = cyc;
      end
      if (cyc == rst_at) begin
        rst_n = 1'b0;
        tick();
        check({tag, "_rst_busy"}, 128'(busy), 128'(0));
        check({tag, "_rst_done"}, 128'(done), 128'(0));
        check({tag, "_rst_tt"}, tt, 128'(0));
        rst_n = 1'b1;
        void'(sb_q.pop_front());
        return;
      end
      start = (cyc == restart_at);
      if (cyc == we_at) begin
        cfg_we   = 1'b1;
        cfg_addr = '0;
        cfg_node = pack_node(0, 1'b1, 0, 1'b1, 0, 1'b1);
      end else begin
        cfg_we = 1'b0;
      end
      if (first_done >= 0 && cyc >= first_done + 5) break;
      tick();
      cyc++;
    end
    start  = 1'b0;
    cfg_we = 1'b0;
    check({tag, "_done_cycle"}, 128'(first_done), 128'(exp_done));
    check({tag, "_busy_cycles"}, 128'(busy_cnt), 128'(exp_done - 1));
    check({tag, "_done_count"}, 128'(dones), 128'(1));
    if (sb_q.size() > 0) exp = sb_q.pop_front();
    else exp = 'x;
    check({tag, "_tt"}, tt, exp);
  endtask

  initial begin
    logic [127:0] chain_tt;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_node = '0;
    cfg_num = '0; cfg_out_inv = 1'b0; start = 1'b0;
    for (int k = 0; k < MAX_GATES; k++)
      for (int j = 0; j < 3; j++) begin tb_sel[k][j] = 0; tb_inv[k][j] = 1'b0; end
    tick(); tick();
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_done", 128'(done), 128'(0));
    check("reset_tt", tt, 128'(0));
    rst_n = 1'b1;
    tick();

    set_node(0, 1, 1'b0, 2, 1'b0, 3, 1'b0);
    sweep("maj012", 1, 1'b0, {16{8'hE8}}, 129, -1, -1, -1);

    set_node(0, 1, 1'b0, 2, 1'b0, 0, 1'b0);
    sweep("and01", 1, 1'b0, {16{8'h88}}, 129, -1, -1, -1);
    sweep("nand01", 1, 1'b1, {16{8'h77}}, 129, -1, -1, -1);

    // Write and start in the same cycle: the sweep must see the new node.
    tb_sel[0][0] = 1; tb_sel[0][1] = 2; tb_sel[0][2] = 0; tb_inv[0][2] = 1'b1;
    cfg_we = 1'b1; cfg_addr = '0; cfg_node = pack_node(1, 1'b0, 2, 1'b0, 0, 1'b1);
    sweep("or01", 1, 1'b0, {16{8'hEE}}, 129, -1, -1, -1);

    set_node(0, 1, 1'b0, 2, 1'b0, 8, 1'b0);
    sweep("selfref", 1, 1'b0, {16{8'h88}}, 129, -1, -1, -1);
    set_node(0, 1, 1'b0, 2, 1'b0, 31, 1'b0);
    sweep("badsel", 1, 1'b0, {16{8'h88}}, 129, -1, -1, -1);

    set_node(0, 1, 1'b0, 2, 1'b0, 3, 1'b0);
    set_node(1, 5, 1'b0, 6, 1'b0, 7, 1'b0);
    set_node(2, 8, 1'b0, 9, 1'b0, 4, 1'b0);
    chain_tt = model_tt(3, 1'b0);
    sweep("chain", 3, 1'b0, chain_tt, 385, -1, -1, -1);
    sweep("chain_restart", 3, 1'b0, chain_tt, 385, 10, -1, -1);
    sweep("chain_we_busy", 3, 1'b0, chain_tt, 385, -1, 20, -1);
    sweep("chain_again", 3, 1'b0, chain_tt, 385, -1, -1, -1);

    sweep("num0", 0, 1'b0, 128'(0), 1, -1, -1, -1);
    sweep("num17", 17, 1'b0, 128'(0), 1, -1, -1, -1);

    sweep("midrst", 3, 1'b0, chain_tt, 385, -1, -1, 50);
    set_node(0, 1, 1'b0, 2, 1'b0, 3, 1'b0);
    set_node(1, 5, 1'b0, 6, 1'b0, 7, 1'b0);
    set_node(2, 8, 1'b0, 9, 1'b0, 4, 1'b0);
    sweep("after_rst", 3, 1'b0, model_tt(3, 1'b0), 385, -1, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
